// File: rtl/video_scanout.sv
// Raster timing generator and pixel/sync alignment stage for the display output.
// Ports: clk, reset, pix_ce, rgb_in[3:0] in; hpos, vpos, active, frame_start,
//   hsync, vsync, de, rgb_out[3:0] out.
module video_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [3:0] rgb_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       active,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [3:0] rgb_out
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] tap;

  // Per-stage bundle {active, hs_raw, vs_raw}; all-zero means blank, sync idle.
  logic [2:0] pipe [PIX_LAT];

  always_comb begin
    active      = (hpos < H_ACT) && (vpos < V_ACT);
    hs_raw      = (hpos >= HS_LO) && (hpos <= HS_HI);
    vs_raw      = (vpos >= VS_LO) && (vpos <= VS_HI);
    frame_start = pix_ce && !reset && (hpos == 10'd0) && (vpos == 10'd0);
    tap         = pipe[PIX_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos <= 10'd0;
      vpos <= 10'd0;
    end else if (pix_ce) begin
      if (hpos == H_LAST) begin
        hpos <= 10'd0;
        vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
      end else begin
        hpos <= hpos + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIX_LAT; i++) pipe[i] <= 3'b000;
    end else if (pix_ce) begin
      pipe[0] <= {active, hs_raw, vs_raw};
      for (int i = 1; i < PIX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Colour is gated by the delayed active bit so junk on rgb_in
  // during blanking never reaches the connector.
  always_ff @(posedge clk) begin
    if (reset) begin
      de      <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
      rgb_out <= 4'b0000;
    end else if (pix_ce) begin
      de      <= tap[2];
      hsync   <= tap[1] ? SYNC_POL : ~SYNC_POL;
      vsync   <= tap[0] ? SYNC_POL : ~SYNC_POL;
      rgb_out <= tap[2] ? rgb_in : 4'b0000;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Randomized bench for video_scanout on a scaled-down raster.
// Expected outputs come from a linear pixel-index model of the frame.
module tb_video_scanout;

  localparam int HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [3:0] rgb_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       active;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [3:0] rgb_out;

  int n_checks = 0;
  int n_pass = 0;
  int k = 0;
  int seed;
  int fs_seen = 0, fs_exp = 0;
  int de_seen = 0, de_exp = 0;
  int adv = 0;

  video_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_LAT(LAT), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_ce(pix_ce),
    .rgb_in(rgb_in),
    .hpos(hpos),
    .vpos(vpos),
    .active(active),
    .frame_start(frame_start),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
  endtask

  function automatic bit vis(input int j);
    return (j % HT) < HA && (j / HT) < VA;
  endfunction

  function automatic logic [3:0] col(input int j);
    return 4'(((j % HT) + 3 * (j / HT) + seed) & 15);
  endfunction

  // One clock: drive inputs after negedge, check, then let the edge happen.
  task automatic step(input logic rst_v, input logic ce_v);
    int idx, j, h, v;
    bit e_de, e_hs, e_vs, e_fs;
    logic [3:0] e_rgb;
    reset  = rst_v;
    pix_ce = ce_v;
    if (k >= LAT && vis((k - LAT) % FR)) rgb_in = col((k - LAT) % FR);
    else rgb_in = 4'bxxxx;
    #1;
    idx = k % FR;
    e_fs = !rst_v && ce_v && idx == 0;
    if (k < LAT + 1) begin
      e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 4'd0;
    end else begin
      j = (k - LAT - 1) % FR;
      h = j % HT;
      v = j / HT;
      e_de = vis(j);
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(v >= VA + VF && v < VA + VF + VS);
      e_rgb = e_de ? col(j) : 4'd0;
    end
    check("hpos", 32'(hpos), 32'(idx % HT));
    check("vpos", 32'(vpos), 32'(idx / HT));
    check("active", 32'(active), 32'(vis(idx)));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("de", 32'(de), 32'(e_de));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("rgb_out", 32'(rgb_out), 32'(e_rgb));
    if (frame_start === 1'b1) fs_seen++;
    if (e_fs) fs_exp++;
    if (ce_v && !rst_v) begin
      if (de === 1'b1) de_seen++;
      if (e_de) de_exp++;
    end
    @(posedge clk);
    if (rst_v) k = 0;
    else if (ce_v) begin
      k++;
      adv++;
    end
    @(negedge clk);
  endtask

  initial begin
    seed   = int'($urandom_range(0, 15));
    reset  = 1'b1;
    pix_ce = 1'b1;
    rgb_in = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    k = 0;

    // continuous advance for two frames plus a bit
    repeat (2 * FR + 50) step(1'b0, 1'b1);
    check("fs_count_a", 32'(fs_seen), 32'(fs_exp));
    check("de_count_a", 32'(de_seen), 32'(de_exp));

    // sparse advance, roughly 1 in 4 clocks
    adv = 0;
    for (int c = 0; c < 20000 && adv < 2 * FR; c++)
      step(1'b0, $urandom_range(0, 3) == 0);
    check("sparse_adv", 32'(adv), 32'(2 * FR));

    // reset mid-frame at (10,3)
    for (int c = 0; c < 4000 && (k % FR) != 3 * HT + 10; c++)
      step(1'b0, $urandom_range(0, 1) == 1);
    check("reach_mid", 32'(k % FR), 32'(3 * HT + 10));
    step(1'b1, 1'b1);
    repeat (FR + 200) step(1'b0, $urandom_range(0, 1) == 1);

    check("fs_count", 32'(fs_seen), 32'(fs_exp));
    check("de_count", 32'(de_seen), 32'(de_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
